// File: rtl/mole_pkg.sv
// mole_pkg: shared definitions for the mole hit judge.
//   NUM_MOLES     - number of mole positions / buttons
//   SCORE_MAX_BCD - saturation value of the two-digit BCD score
//   state_t       - judge FSM states
//   bcd_inc/dec   - saturating 8-bit BCD increment / decrement
package mole_pkg;

    localparam int         NUM_MOLES     = 3;
    localparam logic [7:0] SCORE_MAX_BCD = 8'h99;

    typedef enum logic [1:0] {
        S_OFF,
        S_EMPTY,
        S_ARMED,
        S_DONE
    } state_t;

    // Saturates at 99; units roll 9 -> 0 with a carry into tens.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == SCORE_MAX_BCD) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Floors at 00; units roll 0 -> 9 with a borrow from tens.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = v;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: conditions one raw push-button.
//   2-flop synchroniser -> debounce counter -> registered press pulse.
// Ports:
//   clk_i   - system clock
//   rst_i   - asynchronous active-high reset
//   btn_i   - raw asynchronous button level
//   press_o - one-cycle pulse on the accepted level's 0->1 edge
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 20
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            level_prev_q;
    logic            press_q;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // The counter measures how long the synchronised level has disagreed
    // with the accepted level; any agreement restarts the measurement.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + DB_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            cnt_q        <= cnt_d;
            level_prev_q <= level_q;
            // Rising edge of the accepted level only; releases are silent.
            press_q      <= level_q & ~level_prev_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/mole_hit_judge.sv
// mole_hit_judge: player-side responder for the mole display.
//   Conditions the buttons, judges presses against the mole lines,
//   returns the level turnoff acknowledge and keeps a BCD score.
// Ports:
//   clock, reset  - clock / asynchronous active-high reset
//   game          - 1 = game running, 0 = idle (score held at 00)
//   button[2:0]   - raw push-buttons, bit i is mole i
//   mole[2:0]     - mole-visible lines from the display controller
//   turnoff       - level acknowledge: the current mole was hit
//   hit_pulse     - one cycle per scored hit
//   miss_pulse    - one cycle per penalised wrong press
//   escape_pulse  - one cycle when a mole vanishes unhit
//   score[7:0]    - BCD score, tens in [7:4], units in [3:0]
module mole_hit_judge
    import mole_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 20
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 game,
    input  logic [NUM_MOLES-1:0] button,
    input  logic [NUM_MOLES-1:0] mole,
    output logic                 turnoff,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 escape_pulse,
    output logic [7:0]           score
);

    logic [NUM_MOLES-1:0] press_evt;

    // Conditioners run regardless of game so a button held across a game
    // restart has already been accepted and yields no false press.
    for (genvar gi = 0; gi < NUM_MOLES; gi++) begin : g_cond
        button_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .DB_W           (DB_W)
        ) u_cond (
            .clk_i  (clock),
            .rst_i  (reset),
            .btn_i  (button[gi]),
            .press_o(press_evt[gi])
        );
    end

    state_t     state_q;
    logic [7:0] score_q;
    logic       turnoff_q, hit_q, miss_q, escape_q;

    logic any_match, any_press;
    assign any_match = |(press_evt & mole);
    assign any_press = |press_evt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_OFF;
            score_q   <= 8'h00;
            turnoff_q <= 1'b0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            escape_q  <= 1'b0;
        end else begin
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            escape_q <= 1'b0;
            if (!game) begin
                state_q   <= S_OFF;
                score_q   <= 8'h00;
                turnoff_q <= 1'b0;
            end else begin
                case (state_q)
                    S_OFF: begin
                        score_q   <= 8'h00;
                        turnoff_q <= 1'b0;
                        state_q   <= S_EMPTY;
                    end
                    S_EMPTY: begin
                        if (mole != '0) state_q <= S_ARMED;
                    end
                    S_ARMED: begin
                        // Hit wins over a simultaneous wrong press, and a press
                        // in the cycle the mole drops is still judged.
                        if (any_match) begin
                            score_q   <= bcd_inc(score_q);
                            hit_q     <= 1'b1;
                            turnoff_q <= 1'b1;
                            state_q   <= S_DONE;
                        end else if (any_press) begin
                            score_q <= bcd_dec(score_q);
                            miss_q  <= 1'b1;
                        end else if (mole == '0) begin
                            escape_q <= 1'b1;
                            state_q  <= S_EMPTY;
                        end
                    end
                    S_DONE: begin
                        if (mole == '0) begin
                            turnoff_q <= 1'b0;
                            state_q   <= S_EMPTY;
                        end
                    end
                    default: begin
                        state_q   <= S_OFF;
                        turnoff_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign turnoff      = turnoff_q;
    assign hit_pulse    = hit_q;
    assign miss_pulse   = miss_q;
    assign escape_pulse = escape_q;
    assign score        = score_q;

endmodule

// File: tb/tb_mole_hit_judge.sv
module tb_mole_hit_judge;

    localparam int DEB = 4;

    logic       clock = 1'b0;
    logic       reset, game;
    logic [2:0] button, mole;
    logic       turnoff, hit_pulse, miss_pulse, escape_pulse;
    logic [7:0] score;

    int errors = 0;
    int checks = 0;
    int n_hit, n_miss, n_esc;

    mole_hit_judge #(.DEBOUNCE_CYCLES(DEB), .DB_W(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .game        (game),
        .button      (button),
        .mole        (mole),
        .turnoff     (turnoff),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse),
        .escape_pulse(escape_pulse),
        .score       (score)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Score kept as a plain integer; the debounce is modelled as "the last
    // DEB synchronised samples all disagree with the accepted level", using
    // a history of raw samples (synchronised value = raw two edges ago).
    localparam int M_OFF = 0, M_EMPTY = 1, M_ARMED = 2, M_DONE = 3;
    int         m_st, m_score;
    bit         m_to, m_hit, m_miss, m_esc;
    logic [2:0] hist [DEB+2];
    logic [2:0] m_lvl, m_pe, m_rp;

    function automatic logic [7:0] to_bcd(input int s);
        return 8'(((s / 10) << 4) | (s % 10));
    endfunction

    task automatic model_reset();
        m_st = M_OFF; m_score = 0; m_to = 0; m_hit = 0; m_miss = 0; m_esc = 0;
        for (int i = 0; i < DEB + 2; i++) hist[i] = 3'b000;
        m_lvl = 3'b000; m_pe = 3'b000; m_rp = 3'b000;
    endtask

    task automatic model_step();
        logic [2:0] rise;
        bit all_diff;
        if (reset) begin
            model_reset();
            return;
        end
        m_hit = 0; m_miss = 0; m_esc = 0;
        if (!game) begin
            m_st = M_OFF; m_score = 0; m_to = 0;
        end else if (m_st == M_OFF) begin
            m_st = M_EMPTY;
        end else if (m_st == M_EMPTY) begin
            if (mole != 0) m_st = M_ARMED;
        end else if (m_st == M_ARMED) begin
            if ((m_pe & mole) != 0) begin
                m_score = (m_score < 99) ? m_score + 1 : 99;
                m_hit = 1; m_to = 1; m_st = M_DONE;
            end else if (m_pe != 0) begin
                m_score = (m_score > 0) ? m_score - 1 : 0;
                m_miss = 1;
            end else if (mole == 0) begin
                m_esc = 1; m_st = M_EMPTY;
            end
        end else begin
            if (mole == 0) begin
                m_to = 0; m_st = M_EMPTY;
            end
        end
        for (int i = DEB + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = button;
        rise = 3'b000;
        for (int b = 0; b < 3; b++) begin
            all_diff = 1;
            for (int k = 2; k < DEB + 2; k++)
                if (hist[k][b] == m_lvl[b]) all_diff = 0;
            if (all_diff) begin
                m_lvl[b] = ~m_lvl[b];
                rise[b]  = m_lvl[b];
            end
        end
        m_pe = m_rp;
        m_rp = rise;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
        n_hit  += int'(hit_pulse);
        n_miss += int'(miss_pulse);
        n_esc  += int'(escape_pulse);
        check("cycle {turnoff,hit,miss,esc,score}",
              int'({turnoff, hit_pulse, miss_pulse, escape_pulse, score}),
              int'({m_to, m_hit, m_miss, m_esc, to_bcd(m_score)}));
    endtask

    task automatic clr_counts();
        n_hit = 0; n_miss = 0; n_esc = 0;
    endtask

    task automatic hold(input logic g, input logic [2:0] b, input logic [2:0] m, input int cyc);
        game = g; button = b; mole = m;
        repeat (cyc) step();
    endtask

    task automatic hit_once();
        clr_counts();
        hold(1'b1, 3'b001, 3'b001, 10);
        hold(1'b1, 3'b000, 3'b000, 10);
        check("hit_once pulses", n_hit, 1);
    endtask

    task automatic miss_once();
        clr_counts();
        hold(1'b1, 3'b100, 3'b010, 10);
        hold(1'b1, 3'b000, 3'b010, 10);
        hold(1'b1, 3'b000, 3'b000, 2);
        check("miss_once pulses", n_miss, 1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       g;
        logic [2:0] b;
        logic [2:0] m;
        int         cyc;
        logic [7:0] sc;
        logic       to;
        int         nh, nm, ne;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{1'b0, 3'b000, 3'b000, 3,  8'h00, 1'b0, 0, 0, 0}; // idle
        tbl[1]  = '{1'b1, 3'b000, 3'b000, 3,  8'h00, 1'b0, 0, 0, 0}; // start
        tbl[2]  = '{1'b1, 3'b001, 3'b001, 10, 8'h01, 1'b1, 1, 0, 0}; // hit, held
        tbl[3]  = '{1'b1, 3'b000, 3'b001, 10, 8'h01, 1'b1, 0, 0, 0}; // release, turnoff held
        tbl[4]  = '{1'b1, 3'b000, 3'b000, 1,  8'h01, 1'b0, 0, 0, 0}; // mole gone -> turnoff drops
        tbl[5]  = '{1'b1, 3'b100, 3'b010, 10, 8'h00, 1'b0, 0, 1, 0}; // miss
        tbl[6]  = '{1'b1, 3'b000, 3'b010, 10, 8'h00, 1'b0, 0, 0, 0}; // release
        tbl[7]  = '{1'b1, 3'b100, 3'b010, 10, 8'h00, 1'b0, 0, 1, 0}; // miss at floor
        tbl[8]  = '{1'b1, 3'b000, 3'b010, 10, 8'h00, 1'b0, 0, 0, 0}; // release
        tbl[9]  = '{1'b1, 3'b000, 3'b000, 2,  8'h00, 1'b0, 0, 0, 1}; // escape
        tbl[10] = '{1'b1, 3'b000, 3'b100, 3,  8'h00, 1'b0, 0, 0, 0}; // mole 100
        tbl[11] = '{1'b1, 3'b000, 3'b000, 2,  8'h00, 1'b0, 0, 0, 1}; // escape, no press
        tbl[12] = '{1'b1, 3'b011, 3'b001, 10, 8'h01, 1'b1, 1, 0, 0}; // match + wrong -> hit only
        tbl[13] = '{1'b1, 3'b000, 3'b000, 10, 8'h01, 1'b0, 0, 0, 0}; // done -> empty

        reset = 1'b1; game = 1'b0; button = 3'b000; mole = 3'b000;
        model_reset();
        clr_counts();
        #1;
        repeat (3) step();
        check("reset score", int'(score), 0);
        check("reset flags", int'({turnoff, hit_pulse, miss_pulse, escape_pulse}), 0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            clr_counts();
            hold(tbl[i].g, tbl[i].b, tbl[i].m, tbl[i].cyc);
            check($sformatf("vec%0d score", i), int'(score), int'(tbl[i].sc));
            check($sformatf("vec%0d turnoff", i), int'(turnoff), int'(tbl[i].to));
            check($sformatf("vec%0d hits", i), n_hit, tbl[i].nh);
            check($sformatf("vec%0d misses", i), n_miss, tbl[i].nm);
            check($sformatf("vec%0d escapes", i), n_esc, tbl[i].ne);
        end

        // Bounce: runs of 2 never reach the debounce threshold.
        clr_counts();
        for (int k = 0; k < 10; k++) hold(1'b1, (k % 2 == 0) ? 3'b010 : 3'b000, 3'b010, 2);
        check("bounce hits", n_hit, 0);
        check("bounce misses", n_miss, 0);
        check("bounce score", int'(score), 8'h01);
        hold(1'b1, 3'b010, 3'b010, 10);
        check("stable after bounce hits", n_hit, 1);
        check("stable after bounce score", int'(score), 8'h02);
        hold(1'b1, 3'b000, 3'b000, 10);

        // Score 05, two wrong presses -> 03.
        repeat (3) hit_once();
        check("score five", int'(score), 8'h05);
        miss_once();
        miss_once();
        check("two misses", int'(score), 8'h03);

        // BCD boundaries.
        repeat (6) hit_once();
        check("score nine", int'(score), 8'h09);
        hit_once();
        check("09 + hit", int'(score), 8'h10);
        miss_once();
        check("10 - miss", int'(score), 8'h09);
        repeat (90) hit_once();
        check("score 99", int'(score), 8'h99);
        hit_once();
        check("99 + hit saturates", int'(score), 8'h99);

        // Game drop while in S_DONE with score 12.
        hold(1'b0, 3'b000, 3'b000, 1);
        check("drop to idle", int'(score), 8'h00);
        repeat (11) hit_once();
        clr_counts();
        hold(1'b1, 3'b001, 3'b001, 10);
        check("score 12 done", int'(score), 8'h12);
        check("turnoff in done", int'(turnoff), 1);
        hold(1'b0, 3'b001, 3'b001, 1);
        check("game drop score", int'(score), 8'h00);
        check("game drop turnoff", int'(turnoff), 0);
        hold(1'b0, 3'b000, 3'b000, 10);

        // Async reset while armed with a nonzero score.
        repeat (2) hit_once();
        hold(1'b1, 3'b000, 3'b010, 3);
        check("armed score before reset", int'(score), 8'h02);
        reset = 1'b1;
        #1;
        check("async reset score", int'(score), 0);
        check("async reset flags", int'({turnoff, hit_pulse, miss_pulse, escape_pulse}), 0);
        model_reset();
        hold(1'b1, 3'b000, 3'b010, 2);
        reset = 1'b0;
        hold(1'b1, 3'b000, 3'b000, 10);

        // Randomised segments against the model.
        for (int s = 0; s < 300; s++) begin
            logic       g;
            logic [2:0] b, m;
            g = ($urandom_range(0, 15) != 0);
            m = 3'($urandom_range(0, 7));
            b = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            hold(g, b, m, $urandom_range(1, 14));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
